// File: rtl/reg_to_apb_pkg.sv
// rtl/reg_to_apb_pkg.sv - shared FSM state type and strobe-width helper for the reg-bus to APB bridge
package reg_to_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/reg_to_apb_if.sv
// rtl/reg_to_apb_if.sv - register-bus and APB4 interfaces with master/slave modports
interface reg_bus_if
  import reg_to_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  localparam int STRB_WIDTH = strb_width(DATA_WIDTH);

  logic                  reg_valid_i;
  logic                  reg_write_i;
  logic [ADDR_WIDTH-1:0] reg_addr_i;
  logic [DATA_WIDTH-1:0] reg_wdata_i;
  logic [STRB_WIDTH-1:0] reg_wstrb_i;
  logic                  reg_ready_o;
  logic [DATA_WIDTH-1:0] reg_rdata_o;
  logic                  reg_error_o;

  modport master (
    output reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    input  reg_ready_o, reg_rdata_o, reg_error_o
  );

  modport slave (
    input  reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    output reg_ready_o, reg_rdata_o, reg_error_o
  );
endinterface

interface apb_if
  import reg_to_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  localparam int STRB_WIDTH = strb_width(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] paddr_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [STRB_WIDTH-1:0] pstrb_o;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pready_i;
  logic                  pslverr_i;

  modport master (
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport slave (
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output prdata_i, pready_i, pslverr_i
  );
endinterface

// File: rtl/reg_to_apb.sv
// rtl/reg_to_apb.sv - reg-bus slave to APB4 master bridge, one outstanding transfer; REG_TO_APB_TIMEOUT_EN adds an ACCESS timeout
module reg_to_apb
  import reg_to_apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  reg_bus_if.slave reg_bus,
  apb_if.master    apb
);
  localparam int STRB = strb_width(DATA_WIDTH);

  if ((DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("reg_to_apb: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 2");
  end

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB-1:0]       wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  error_q;

  logic psel, penable, ready;
  logic accept, complete;
  logic timeout;

`ifdef REG_TO_APB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] count_q;

  // Counter is held at zero outside ACCESS, so it starts fresh on every entry.
  assign timeout = (state_q == ACCESS) && !apb.pready_i
                   && (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (state_q != ACCESS) begin
      count_q <= '0;
    end else if (!apb.pready_i) begin
      count_q <= count_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign accept   = (state_q == IDLE) && reg_bus.reg_valid_i;
  assign complete = (state_q == ACCESS) && apb.pready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    psel    = 1'b0;
    penable = 1'b0;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (reg_bus.reg_valid_i) state_d = SETUP;
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (apb.pready_i || timeout) state_d = RESP;
      end
      RESP: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      addr_q  <= reg_bus.reg_addr_i;
      write_q <= reg_bus.reg_write_i;
      wdata_q <= reg_bus.reg_wdata_i;
      wstrb_q <= reg_bus.reg_write_i ? reg_bus.reg_wstrb_i : '0;
    end
  end

  // A real pready beats a timeout that lands in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end else if (complete) begin
      rdata_q <= write_q ? '0 : apb.prdata_i;
      error_q <= apb.pslverr_i;
    end else if (timeout) begin
      rdata_q <= '0;
      error_q <= 1'b1;
    end
  end

  assign apb.paddr_o   = addr_q;
  assign apb.psel_o    = psel;
  assign apb.penable_o = penable;
  assign apb.pwrite_o  = write_q;
  assign apb.pwdata_o  = wdata_q;
  assign apb.pstrb_o   = wstrb_q;

  assign reg_bus.reg_ready_o = ready;
  assign reg_bus.reg_rdata_o = rdata_q;
  assign reg_bus.reg_error_o = error_q;

endmodule

// File: tb/tb_reg_to_apb.sv
// tb/tb_reg_to_apb.sv - directed self-checking bench for reg_to_apb (covers both REG_TO_APB_TIMEOUT_EN builds)
module tb_reg_to_apb;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  reg_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) rb ();
  apb_if     #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ab ();

  reg_to_apb #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .reg_bus (rb),
    .apb     (ab)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the IDLE cycle that samples valid; ready is expected in cycle 3 + waits.
  task automatic xfer(input string name, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] ws, input int waits,
                      input logic [31:0] rd, input logic err,
                      input logic [31:0] exp_rdata, input logic keep);
    int last;
    last = 3 + waits;
    rb.reg_valid_i = 1'b1;
    rb.reg_write_i = wr;
    rb.reg_addr_i  = a;
    rb.reg_wdata_i = wd;
    rb.reg_wstrb_i = ws;
    for (int k = 0; k <= last; k++) begin
      if (k == last - 1) begin
        ab.pready_i  = 1'b1;
        ab.prdata_i  = rd;
        ab.pslverr_i = err;
      end else begin
        ab.pready_i  = 1'b0;
        ab.prdata_i  = 32'hBAD0_BAD0;
        ab.pslverr_i = 1'b1;
      end
      check($sformatf("%s.psel@%0d", name, k), ab.psel_o, (k >= 1 && k < last));
      check($sformatf("%s.penable@%0d", name, k), ab.penable_o, (k >= 2 && k < last));
      check($sformatf("%s.ready@%0d", name, k), rb.reg_ready_o, (k == last));
      if (k >= 1 && k < last) begin
        check($sformatf("%s.paddr@%0d", name, k), ab.paddr_o, a);
        check($sformatf("%s.pwrite@%0d", name, k), ab.pwrite_o, wr);
        check($sformatf("%s.pstrb@%0d", name, k), ab.pstrb_o, wr ? ws : 4'h0);
        if (wr) check($sformatf("%s.pwdata@%0d", name, k), ab.pwdata_o, wd);
      end
      if (k == last) begin
        check($sformatf("%s.rdata", name), rb.reg_rdata_o, exp_rdata);
        check($sformatf("%s.error", name), rb.reg_error_o, err);
        if (!keep) rb.reg_valid_i = 1'b0;
      end
      tick();
    end
    ab.pready_i  = 1'b0;
    ab.pslverr_i = 1'b0;
  endtask

  initial begin
    int pulses;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    rb.reg_valid_i = 1'b0;
    rb.reg_write_i = 1'b0;
    rb.reg_addr_i  = '0;
    rb.reg_wdata_i = '0;
    rb.reg_wstrb_i = '0;
    ab.prdata_i    = '0;
    ab.pready_i    = 1'b0;
    ab.pslverr_i   = 1'b0;

    tick();
    tick();
    check("rst.psel", ab.psel_o, 1'b0);
    check("rst.penable", ab.penable_o, 1'b0);
    check("rst.ready", rb.reg_ready_o, 1'b0);
    check("rst.paddr", ab.paddr_o, 32'h0);
    check("rst.pwdata", ab.pwdata_o, 32'h0);
    check("rst.pstrb", ab.pstrb_o, 4'h0);
    check("rst.pwrite", ab.pwrite_o, 1'b0);
    check("rst.rdata", rb.reg_rdata_o, 32'h0);
    check("rst.error", rb.reg_error_o, 1'b0);
    rst_n = 1'b1;
    tick();

    xfer("wr0", 1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 0, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
    xfer("rd_wait", 1'b0, 32'h0000_0020, 32'h5555_AAAA, 4'hF, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0);
    xfer("rd_err", 1'b0, 32'h0000_0030, 32'h0, 4'h0, 0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0);

    // Valid held across two requests: the second is sampled in the IDLE after RESP.
    xfer("b2b_a", 1'b1, 32'h0000_0100, 32'h1111_2222, 4'h3, 0, 32'h0, 1'b0, 32'h0, 1'b1);
    xfer("b2b_b", 1'b0, 32'h0000_0104, 32'h0, 4'hC, 0, 32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A, 1'b0);

    rb.reg_valid_i = 1'b1;
    rb.reg_write_i = 1'b0;
    rb.reg_addr_i  = 32'h0000_0044;
    tick();
    tick();
    check("rst_mid.psel_before", ab.psel_o, 1'b1);
    check("rst_mid.penable_before", ab.penable_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.psel", ab.psel_o, 1'b0);
    check("rst_mid.penable", ab.penable_o, 1'b0);
    check("rst_mid.ready", rb.reg_ready_o, 1'b0);
    check("rst_mid.paddr", ab.paddr_o, 32'h0);
    rb.reg_valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid.idle_ready", rb.reg_ready_o, 1'b0);
    xfer("after_rst", 1'b1, 32'h0000_0048, 32'h0BAD_CAFE, 4'h5, 1, 32'h0, 1'b0, 32'h0, 1'b0);

`ifdef REG_TO_APB_TIMEOUT_EN
    rb.reg_valid_i = 1'b1;
    rb.reg_write_i = 1'b0;
    rb.reg_addr_i  = 32'h0000_0050;
    ab.pready_i    = 1'b0;
    ab.prdata_i    = 32'h7777_7777;
    ab.pslverr_i   = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      check($sformatf("tmo.psel@%0d", k), ab.psel_o, (k >= 1 && k < 6));
      check($sformatf("tmo.ready@%0d", k), rb.reg_ready_o, (k == 6));
      if (k == 6) begin
        check("tmo.error", rb.reg_error_o, 1'b1);
        check("tmo.rdata", rb.reg_rdata_o, 32'h0);
        rb.reg_valid_i = 1'b0;
      end
      tick();
    end
`else
    rb.reg_valid_i = 1'b1;
    rb.reg_write_i = 1'b0;
    rb.reg_addr_i  = 32'h0000_0050;
    ab.pready_i    = 1'b0;
    pulses = 0;
    for (int k = 0; k < 1000; k++) begin
      if (rb.reg_ready_o) pulses++;
      tick();
    end
    check("no_tmo.ready_pulses", pulses, 0);
    check("no_tmo.psel_held", ab.psel_o, 1'b1);
    check("no_tmo.penable_held", ab.penable_o, 1'b1);
    rb.reg_valid_i = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
